// File: rtl/pixel_stream_packer.sv
// Turns pixel_top's read/data_out samples into intensity pixels tagged with frame position,
// buffered in a small FIFO and offered on a valid/ready stream.
module pixel_stream_packer #(
    parameter int array_width   = 100,
    parameter int array_height  = 100,
    parameter int counter_width = 8,
    parameter int fifo_depth    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          read,
    input  logic [counter_width-1:0]      data_out,
    input  logic                          pix_ready,
    output logic                          pix_valid,
    output logic [counter_width-1:0]      pix_data,
    output logic                          pix_sof,
    output logic                          pix_eol,
    output logic                          pix_eof,
    output logic [$clog2(fifo_depth):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   frame_count
);
    localparam int col_w   = $clog2(array_width);
    localparam int row_w   = $clog2(array_height);
    localparam int ptr_w   = $clog2(fifo_depth);
    localparam int entry_w = counter_width + 3;

    localparam logic [col_w-1:0]         col_last   = col_w'(array_width - 1);
    localparam logic [row_w-1:0]         row_last   = row_w'(array_height - 1);
    localparam logic [ptr_w:0]           level_full = (ptr_w + 1)'(fifo_depth);
    localparam logic [counter_width-1:0] code_max   = '1;

    logic [col_w-1:0]   col;
    logic [row_w-1:0]   row;
    logic [entry_w-1:0] mem [fifo_depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w:0]     level;
    logic               full;
    logic               pop;
    logic               push;
    logic               tag_sof;
    logic               tag_eol;
    logic               tag_eof;
    logic [entry_w-1:0] entry;
    logic [entry_w-1:0] head;

    always_comb begin
        tag_sof = (col == '0) && (row == '0);
        tag_eol = (col == col_last);
        tag_eof = tag_eol && (row == row_last);
        entry   = {tag_eof, tag_eol, tag_sof, code_max - data_out};
        full    = (level == level_full);
        pop     = (level != '0) && pix_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
        push    = read && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col         <= '0;
            row         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            // Position advances on every read, stored or dropped, to keep frame alignment.
            if (read) begin
                if (col == col_last) begin
                    col <= '0;
                    row <= (row == row_last) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (read && !push)    overflow    <= 1'b1;
            if (push && tag_eof)  frame_count <= frame_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= entry;
    end

    assign head       = mem[rd_ptr];
    assign pix_valid  = (level != '0);
    assign pix_data   = pix_valid ? head[counter_width-1:0] : '0;
    assign pix_sof    = pix_valid & head[counter_width];
    assign pix_eol    = pix_valid & head[counter_width+1];
    assign pix_eof    = pix_valid & head[counter_width+2];
    assign fifo_level = level;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Self-checking bench for pixel_stream_packer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations and a randomized run.
module tb_pixel_stream_packer;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read = 1'b0;
    logic [CW-1:0] data_out = '0;
    logic          pix_ready = 1'b0;
    logic          pix_valid;
    logic [CW-1:0] pix_data;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [15:0]   frame_count;

    pixel_stream_packer #(
        .array_width(W), .array_height(H), .counter_width(CW), .fifo_depth(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .read(read), .data_out(data_out), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_eof(pix_eof), .fifo_level(fifo_level), .overflow(overflow),
        .frame_count(frame_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: entries are {eof, eol, sof, intensity}, position is a linear pixel index
    logic [CW+2:0] exp_q[$];
    int            idx;
    bit            m_ovf;
    int            m_fc;
    bit            stall;
    bit            cmp_en = 1'b0;
    bit            m_pop;
    bit            m_full;
    logic [CW+2:0] m_entry;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            idx   = 0;
            m_ovf = 1'b0;
            m_fc  = 0;
            stall = 1'b0;
        end else begin
            m_pop  = (exp_q.size() != 0) && pix_ready;
            m_full = (exp_q.size() == DEPTH);
            stall  = (exp_q.size() != 0) && !pix_ready;
            if (m_pop) void'(exp_q.pop_front());
            if (read) begin
                m_entry = {1'(idx == W*H-1), 1'(idx % W == W-1), 1'(idx == 0),
                           CW'((1 << CW) - 1 - int'(data_out))};
                if (!m_full || m_pop) begin
                    exp_q.push_back(m_entry);
                    if (idx == W*H-1) m_fc = (m_fc + 1) % 65536;
                end else begin
                    m_ovf = 1'b1;
                end
                idx = (idx + 1) % (W*H);
            end
        end
    end

    // scoreboard compare, away from the active edge
    logic [CW+2:0] cmp_head;
    logic [CW+2:0] prev_out;

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
            check("valid", 32'(pix_valid), 32'(exp_q.size() != 0));
            check("data", 32'(pix_data), 32'(cmp_head[CW-1:0]));
            check("sof", 32'(pix_sof), 32'(cmp_head[CW]));
            check("eol", 32'(pix_eol), 32'(cmp_head[CW+1]));
            check("eof", 32'(pix_eof), 32'(cmp_head[CW+2]));
            check("level", 32'(fifo_level), 32'(exp_q.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("frame_count", 32'(frame_count), 32'(m_fc));
            if (stall) check("stall_stable", 32'({pix_eof, pix_eol, pix_sof, pix_data}), 32'(prev_out));
            prev_out = {pix_eof, pix_eol, pix_sof, pix_data};
        end
    end

    // driver: apply inputs after a negedge, return at the next negedge
    task automatic step(input bit r, input logic [CW-1:0] d, input bit rdy);
        read      = r;
        data_out  = d;
        pix_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, '0, 0);
        reset = 1'b0;
    endtask

    logic [CW-1:0] drain_exp[4];
    int sent;
    int cyc;
    bit rr;
    bit rdy;

    initial begin
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // reset mid-stream with read asserted
        for (int i = 0; i < 5; i++) step(1, 8'h10, 0);
        check("pre_reset_level", 32'(fifo_level), 32'd4);
        check("pre_reset_ovf", 32'(overflow), 32'd1);
        reset = 1'b1;
        step(1, 8'h10, 0);
        reset = 1'b0;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);

        // single pixel, one-cycle latency
        step(1, 8'h30, 1);
        check("single_valid", 32'(pix_valid), 32'd1);
        check("single_data", 32'(pix_data), 32'd207);
        check("single_sof", 32'(pix_sof), 32'd1);
        step(0, '0, 1);
        check("single_level", 32'(fifo_level), 32'd0);

        // full frame, streaming
        do_reset();
        for (int i = 0; i < W*H; i++) begin
            step(1, CW'(i), 1);
            check("frame_data", 32'(pix_data), 32'(255 - i));
            check("frame_sof", 32'(pix_sof), 32'(i == 0));
            check("frame_eol", 32'(pix_eol), 32'(i % 4 == 3));
            check("frame_eof", 32'(pix_eof), 32'(i == 11));
        end
        check("frame_fc", 32'(frame_count), 32'd1);
        step(1, 8'h00, 1);
        check("frame_next_sof", 32'(pix_sof), 32'd1);
        step(0, '0, 1);

        // backpressure and overflow
        do_reset();
        for (int i = 0; i < 6; i++) step(1, CW'(i), 0);
        check("bp_level", 32'(fifo_level), 32'd4);
        check("bp_ovf", 32'(overflow), 32'd1);
        pix_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain", 32'(pix_data), 32'(255 - k));
            step(0, '0, 1);
        end
        check("bp_empty", 32'(fifo_level), 32'd0);
        step(1, 8'd6, 1);
        check("bp_pos6_data", 32'(pix_data), 32'd249);
        check("bp_pos6_eol", 32'(pix_eol), 32'd0);
        step(1, 8'd7, 1);
        check("bp_pos7_eol", 32'(pix_eol), 32'd1);
        step(0, '0, 1);

        // full FIFO with push and pop together
        do_reset();
        for (int i = 0; i < 4; i++) step(1, CW'(i), 0);
        check("pp_full", 32'(fifo_level), 32'd4);
        step(1, 8'd9, 1);
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        drain_exp[0] = 8'd254;
        drain_exp[1] = 8'd253;
        drain_exp[2] = 8'd252;
        drain_exp[3] = 8'd246;
        for (int k = 0; k < 4; k++) begin
            check("pp_drain", 32'(pix_data), 32'(drain_exp[k]));
            step(0, '0, 1);
        end

        // random backpressure over three frames, reads held off only when a drop would occur
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 3*W*H && cyc < 5000) begin
            rdy = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 1) == 1) && ((exp_q.size() < DEPTH) || rdy);
            step(rr, CW'($urandom_range(0, 255)), rdy);
            if (rr) sent++;
            cyc++;
        end
        while (pix_valid && cyc < 5000) begin
            step(0, '0, 1);
            cyc++;
        end
        check("rand_timeout", 32'(cyc < 5000), 32'd1);
        check("rand_fc", 32'(frame_count), 32'd3);
        check("rand_ovf", 32'(overflow), 32'd0);
        check("rand_level", 32'(fifo_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
